divisor_seq: RTL and testbench



---
 rtl/divisor_seq.sv | 160 ++++++++++++++++
 tb/tb_divisor_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/divisor_seq.sv
// divisor_seq: multi-cycle restoring divider, one quotient bit per clock.
// Unsigned or two's-complement signed mode is selected per operation.
// Ports:
//   clk_i    - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start_i  - request a division (sampled only when idle)
//   sinal_i  - 0 = unsigned, 1 = signed (sampled with start_i)
//   a_i, b_i - dividend and divisor (sampled with start_i)
//   s_o      - quotient, registered
//   resto_o  - remainder, registered
//   div0_o   - last completed operation had a zero divisor
//   busy_o   - operation in progress
//   done_o   - one-cycle pulse when s_o/resto_o/div0_o update
module divisor_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             sinal_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] resto_o,
  output logic             div0_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFim} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] raw_a_q, raw_a_d;   // dividend as captured, for divide-by-zero
  logic [WIDTH-1:0] dvd_q, dvd_d;       // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;       // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;       // partial remainder, always < divisor
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] resto_q, resto_d;
  logic             div0_q, div0_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   trial, diff;
  logic             borrow;
  logic             unused_msb;

  assign a_neg = sinal_i & a_i[WIDTH-1];
  assign b_neg = sinal_i & b_i[WIDTH-1];
  assign a_mag = a_neg ? (~a_i + WIDTH'(1)) : a_i;
  assign b_mag = b_neg ? (~b_i + WIDTH'(1)) : b_i;

  // Trial value is one bit wider than the operands so a divisor above 2^(WIDTH-1)
  // cannot overflow the shifted remainder.
  assign trial  = {rem_q, dvd_q[WIDTH-1]};
  assign diff   = trial - {1'b0, dvs_q};
  assign borrow = trial < {1'b0, dvs_q};
  // Kept remainder is always below the divisor, so the top bit is never needed.
  assign unused_msb = trial[WIDTH] ^ diff[WIDTH];

  always_comb begin
    state_d = state_q;
    raw_a_d = raw_a_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    s_d     = s_q;
    resto_d = resto_q;
    div0_d  = div0_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          raw_a_d = a_i;
          zero_d  = (b_i == '0);
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          dvd_d   = a_mag;
          dvs_d   = b_mag;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = (b_i == '0) ? StFim : StCalc;
        end
      end
      StCalc: begin
        rem_d = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~borrow};
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFim;
        end
      end
      StFim: begin
        done_d  = 1'b1;
        state_d = StIdle;
        if (zero_q) begin
          s_d     = '1;
          resto_d = raw_a_q;
          div0_d  = 1'b1;
        end else begin
          s_d     = qneg_q ? (~dvd_q + WIDTH'(1)) : dvd_q;
          resto_d = rneg_q ? (~rem_q + WIDTH'(1)) : rem_q;
          div0_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      raw_a_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      s_q     <= '0;
      resto_q <= '0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raw_a_q <= raw_a_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      s_q     <= s_d;
      resto_q <= resto_d;
      div0_q  <= div0_d;
      done_q  <= done_d;
    end
  end

  assign s_o     = s_q;
  assign resto_o = resto_q;
  assign div0_o  = div0_q;
  assign done_o  = done_q;
  // Busy covers CALC and FIM; it drops on the edge that raises done.
  assign busy_o  = (state_q != StIdle);

endmodule

// File: tb/tb_divisor_seq.sv
// tb_divisor_seq: directed vector bench for divisor_seq at WIDTH=8 and WIDTH=16.
module tb_divisor_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, sinal;
  logic [7:0] a_in, b_in, s, resto;
  logic       div0, busy, done;

  logic        start16;
  logic [15:0] a16, b16, s16, resto16;
  logic        div016, busy16, done16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  divisor_seq #(.WIDTH(8)) dut (
    .clk_i   (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .sinal_i (sinal),
    .a_i     (a_in),
    .b_i     (b_in),
    .s_o     (s),
    .resto_o (resto),
    .div0_o  (div0),
    .busy_o  (busy),
    .done_o  (done)
  );

  divisor_seq #(.WIDTH(16)) dut16 (
    .clk_i   (clk),
    .rst_n   (rst_n),
    .start_i (start16),
    .sinal_i (1'b0),
    .a_i     (a16),
    .b_i     (b16),
    .s_o     (s16),
    .resto_o (resto16),
    .div0_o  (div016),
    .busy_o  (busy16),
    .done_o  (done16)
  );

  typedef struct {
    logic       sgn;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] es;
    logic [7:0] er;
    logic       ed0;
    int         lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Issue one operation; optionally pulse start with other operands before edge inj.
  task automatic run_op(input string tag, input logic sgn, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] es, input logic [7:0] er,
                        input logic ed0, input int elat, input int inj);
    int lat;
    int busy_n;
    @(negedge clk);
    start = 1'b1;
    sinal = sgn;
    a_in  = a;
    b_in  = b;
    @(posedge clk);
    #1;
    lat    = 0;
    busy_n = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == inj) begin
        start = 1'b1;
        sinal = 1'b0;
        a_in  = 8'd50;
        b_in  = 8'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, elat);
    check({tag, "_busy_cycles"}, busy_n, elat);
    check({tag, "_busy_low_at_done"}, {31'd0, busy}, 0);
    check({tag, "_s"}, {24'd0, s}, {24'd0, es});
    check({tag, "_resto"}, {24'd0, resto}, {24'd0, er});
    check({tag, "_div0"}, {31'd0, div0}, {31'd0, ed0});
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, {31'd0, done}, 0);
  endtask

  initial begin
    int cnt;
    int lat;
    vecs[0]  = '{1'b0, 8'd100, 8'd7,  8'd14, 8'd2,  1'b0, 9};
    vecs[1]  = '{1'b0, 8'hFF,  8'h81, 8'h01, 8'h7E, 1'b0, 9};
    vecs[2]  = '{1'b0, 8'hFF,  8'h01, 8'hFF, 8'h00, 1'b0, 9};
    vecs[3]  = '{1'b0, 8'h5A,  8'h00, 8'hFF, 8'h5A, 1'b1, 1};
    vecs[4]  = '{1'b0, 8'd9,   8'd3,  8'd3,  8'd0,  1'b0, 9};
    vecs[5]  = '{1'b1, 8'hF9,  8'h02, 8'hFD, 8'hFF, 1'b0, 9};
    vecs[6]  = '{1'b1, 8'h07,  8'hFE, 8'hFD, 8'h01, 1'b0, 9};
    vecs[7]  = '{1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 9};
    vecs[8]  = '{1'b1, 8'hF9,  8'h00, 8'hFF, 8'hF9, 1'b1, 1};
    vecs[9]  = '{1'b1, 8'h9C,  8'h07, 8'hF2, 8'hFE, 1'b0, 9};
    vecs[10] = '{1'b0, 8'h10,  8'h20, 8'h00, 8'h10, 1'b0, 9};

    rst_n   = 1'b0;
    start   = 1'b0;
    sinal   = 1'b0;
    a_in    = '0;
    b_in    = '0;
    start16 = 1'b0;
    a16     = '0;
    b16     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_s", {24'd0, s}, 0);
    check("reset_resto", {24'd0, resto}, 0);
    check("reset_div0", {31'd0, div0}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].es,
             vecs[i].er, vecs[i].ed0, vecs[i].lat, 0);
    end

    // start pulsed on edge 3 of an in-flight op must be ignored
    run_op("ignored_start", 1'b0, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9, 3);
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("no_second_done", cnt, 0);
    check("held_s", {24'd0, s}, 32'd14);

    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1;
    sinal = 1'b0;
    a_in  = 8'd100;
    b_in  = 8'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_s", {24'd0, s}, 0);
    check("midrst_resto", {24'd0, resto}, 0);
    check("midrst_div0", {31'd0, div0}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    cnt = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
    check("midrst_no_done", cnt, 0);
    #2;
    rst_n = 1'b1;
    run_op("after_rst", 1'b0, 8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 9, 0);

    // WIDTH=16 latency
    @(negedge clk);
    start16 = 1'b1;
    a16     = 16'd100;
    b16     = 16'd7;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done16) begin
        lat = k;
        break;
      end
    end
    check("w16_latency", lat, 17);
    check("w16_s", {16'd0, s16}, 32'd14);
    check("w16_resto", {16'd0, resto16}, 32'd2);
    check("w16_div0", {31'd0, div016}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
